ps2_scan_sequencer: RTL

Sits between the PS/2 byte deserializer and the seven-segment/display logic. It performs these steps:
- Synchronizes the deserializer's byte-ready strobe into the system clock domain.
- Parses scan-code set 2 prefix sequences (E0, F0, E0 F0, E1 Pause) into single key events.
- Applies an inter-byte timeout.
- Buffers decoded events in a small FIFO drained with a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_event_fifo.sv | 65 ++++++
 rtl/ps2_scan_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 scan sequencer.
// Holds the parser state enum and the packed key event bundle.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GOT_E0   = 3'd1,
        ST_GOT_F0   = 3'd2,
        ST_GOT_E0F0 = 3'd3,
        ST_PAUSE    = 3'd4
    } parser_state_t;

    localparam logic [7:0] SC_EXT        = 8'hE0;
    localparam logic [7:0] SC_BRK        = 8'hF0;
    localparam logic [7:0] SC_PAUSE      = 8'hE1;
    localparam logic [7:0] SC_BAT        = 8'hAA;
    localparam logic [7:0] SC_ACK        = 8'hFA;
    localparam logic [7:0] SC_PAUSE_CODE = 8'h77;
    localparam int         PAUSE_TAIL    = 7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    function automatic key_event_t mk_event(
        input logic [7:0] code,
        input logic       ext,
        input logic       brk
    );
        key_event_t e;
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        return e;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO of key_event_t with occupancy count.
// Ports: clk, reset (async active-low), i_wr/i_wdata push side,
// i_rd_ready pop side, o_valid/o_rdata head, o_count, o_drop
// (push rejected because full with no simultaneous pop).
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr,
    input  key_event_t             i_wdata,
    input  logic                   i_rd_ready,
    output logic                   o_valid,
    output key_event_t             o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    key_event_t    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_write;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = ~w_empty & i_rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_write = i_wr & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) r_wptr <= r_wptr + AW'(1);
            if (w_pop)   r_rptr <= r_rptr + AW'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wptr] <= i_wdata;
    end

    assign o_valid = ~w_empty;
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_drop  = i_wr & w_full & ~w_pop;

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 set-2 scan sequencer: strobe sync, prefix parser, inter-byte
// timeout, optional typematic filter (PS2_TYPEMATIC_FILTER_EN), FIFO.
// Ports: clk, reset (async active-low), byte_ready/byte_data in,
// event_valid/ready/code/ext/break out, fifo_count, overflow,
// protocol_err (both sticky until reset).
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        byte_ready,
    input  logic [7:0]                  byte_data,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [7:0]                  event_code,
    output logic                        event_ext,
    output logic                        event_break,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        protocol_err
);

    localparam int          TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  PT_MAX = 3'(PAUSE_TAIL - 1);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_strobe;

    parser_state_t r_state;
    parser_state_t w_state_nxt;
    logic [2:0]    r_pcnt;
    logic [2:0]    w_pcnt_nxt;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_nxt;

    logic       w_push_raw;
    logic       w_push;
    key_event_t w_evt;
    logic       w_err;
    logic       w_is_pfx;

    logic       w_fifo_valid;
    key_event_t w_head;
    logic       w_drop;

    logic r_overflow;
    logic r_perr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= byte_ready;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_strobe = r_s2 & ~r_s3;
    assign w_is_pfx = (byte_data == SC_EXT) | (byte_data == SC_BRK) |
                      (byte_data == SC_PAUSE);

    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_to_nxt    = r_to_cnt + TW'(1);
        w_push_raw  = 1'b0;
        w_evt       = mk_event(byte_data, 1'b0, 1'b0);
        w_err       = 1'b0;
        if (w_strobe) begin
            // A byte arriving on the timeout cycle is still processed.
            w_to_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    case (byte_data)
                        SC_EXT:   w_state_nxt = ST_GOT_E0;
                        SC_BRK:   w_state_nxt = ST_GOT_F0;
                        SC_PAUSE: begin
                            w_state_nxt = ST_PAUSE;
                            w_pcnt_nxt  = '0;
                        end
                        SC_BAT, SC_ACK: ;
                        8'h00, 8'hFF: w_err = 1'b1;
                        default:  w_push_raw = 1'b1;
                    endcase
                end
                ST_GOT_E0: begin
                    if (byte_data == SC_BRK) begin
                        w_state_nxt = ST_GOT_E0F0;
                    end else if (w_is_pfx) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_push_raw  = 1'b1;
                        w_evt       = mk_event(byte_data, 1'b1, 1'b0);
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    w_state_nxt = ST_IDLE;
                    if (w_is_pfx) begin
                        w_err = 1'b1;
                    end else begin
                        w_push_raw = 1'b1;
                        w_evt      = mk_event(byte_data, 1'b0, 1'b1);
                    end
                end
                ST_GOT_E0F0: begin
                    w_state_nxt = ST_IDLE;
                    if (w_is_pfx) begin
                        w_err = 1'b1;
                    end else begin
                        w_push_raw = 1'b1;
                        w_evt      = mk_event(byte_data, 1'b1, 1'b1);
                    end
                end
                ST_PAUSE: begin
                    // Pause tail bytes are fixed; only their count matters.
                    if (r_pcnt == PT_MAX) begin
                        w_push_raw  = 1'b1;
                        w_evt       = mk_event(SC_PAUSE_CODE, 1'b1, 1'b0);
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pcnt_nxt = r_pcnt + 3'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state == ST_IDLE) begin
            w_to_nxt = '0;
        end else if (r_to_cnt == TO_MAX) begin
            w_to_nxt    = '0;
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_pcnt   <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       r_held_vld;
    logic [7:0] r_held_code;
    logic       r_held_ext;
    logic       w_match;

    assign w_match = r_held_vld & (w_evt.code == r_held_code) &
                     (w_evt.ext == r_held_ext);
    // Repeated makes of the held key are auto-repeat; breaks always pass.
    assign w_push  = w_push_raw & (w_evt.brk | ~w_match);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held_vld  <= 1'b0;
            r_held_code <= '0;
            r_held_ext  <= 1'b0;
        end else if (w_push_raw) begin
            if (!w_evt.brk && !w_match) begin
                r_held_vld  <= 1'b1;
                r_held_code <= w_evt.code;
                r_held_ext  <= w_evt.ext;
            end else if (w_evt.brk && w_match) begin
                r_held_vld <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_push_raw;
`endif

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr       (w_push),
        .i_wdata    (w_evt),
        .i_rd_ready (event_ready),
        .o_valid    (w_fifo_valid),
        .o_rdata    (w_head),
        .o_count    (fifo_count),
        .o_drop     (w_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_overflow <= r_overflow | w_drop;
            r_perr     <= r_perr | w_err;
        end
    end

    // Head fields are forced to zero while empty so reset shows all zeros.
    assign event_valid  = w_fifo_valid;
    assign event_code   = w_fifo_valid ? w_head.code : 8'h00;
    assign event_ext    = w_fifo_valid & w_head.ext;
    assign event_break  = w_fifo_valid & w_head.brk;
    assign overflow     = r_overflow;
    assign protocol_err = r_perr;

endmodule
